// File: rtl/pke_v2_if.sv
// Frame bus between the upstream switch pipeline and the packet key extractor:
// frame/valid strobes in, ready back, and the re-timed frame stream plus key out.
interface pke_v2_if;
  logic [133:0] in_pke_data;
  logic         in_pke_data_wr;
  logic         in_pke_valid;
  logic         in_pke_valid_wr;
  logic         in_pke_ready;

  logic [133:0] out_pke_data;
  logic         out_pke_data_wr;
  logic         out_pke_valid;
  logic         out_pke_valid_wr;
  logic [2:0]   out_pke_pkttype;
  logic [101:0] out_pke_key;

  modport master (
    output in_pke_data, in_pke_data_wr, in_pke_valid, in_pke_valid_wr,
    input  in_pke_ready,
    input  out_pke_data, out_pke_data_wr, out_pke_valid, out_pke_valid_wr,
    input  out_pke_pkttype, out_pke_key
  );

  modport slave (
    input  in_pke_data, in_pke_data_wr, in_pke_valid, in_pke_valid_wr,
    output in_pke_ready,
    output out_pke_data, out_pke_data_wr, out_pke_valid, out_pke_valid_wr,
    output out_pke_pkttype, out_pke_key
  );
endinterface

// File: rtl/pke_v2.sv
// Packet key extractor: buffers metadata + Ethernet header frames, latches the
// lookup key and traffic class, then forwards the packet delayed by the buffer depth.
module pke_v2 #(
  parameter int          MD_FRAMES  = 2,
  parameter logic [23:0] PCP_MAP    = 24'o33111000,
  parameter logic [15:0] PTP_ETYPE  = 16'h88F7,
  parameter logic [15:0] VLAN_ETYPE = 16'h8100,
  parameter logic [2:0]  UNTAG_TYPE = 3'h0,
  parameter logic [2:0]  PTP_TYPE   = 3'h2
) (
  input  logic        clk,
  input  logic        rst_n,
  pke_v2_if.slave     pke,
  output logic [63:0] esw_pktin_cnt,
  output logic [31:0] pke_err_cnt
);

  localparam int         DEPTH   = MD_FRAMES + 1;
  localparam logic [2:0] DEPTH_C = 3'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_PASS, S_DRAIN} state_t;

  state_t                    state_q, state_d;
  logic [2:0]                cnt_q, cnt_d;
  logic [DEPTH-1:0][133:0]   buf_q;
  logic [133:0]              out_data_q;
  logic                      out_wr_q;
  logic                      out_valid_q;
  logic [2:0]                pkttype_q, pkttype_d;
  logic [101:0]              key_q;

  logic       ready, accept, is_head, is_tail;
  logic       shift_en, load_in, emit, emit_last, head_start, classify, err_inc;
  logic [2:0] cnt_inc;
  logic [4:0] map_lsb;
  logic       unused_valid;

  assign ready        = (state_q != S_DRAIN);
  assign accept       = pke.in_pke_data_wr && ready;
  assign is_head      = (pke.in_pke_data[133:132] == 2'b01);
  assign is_tail      = (pke.in_pke_data[133:132] == 2'b10);
  assign cnt_inc      = cnt_q + 3'd1;
  assign map_lsb      = {1'b0, pke.in_pke_data[15:13], 1'b0} + {2'b00, pke.in_pke_data[15:13]};
  // The per-packet valid level carries no information here; only its strobe is counted.
  assign unused_valid = pke.in_pke_valid;

  always_comb begin
    pkttype_d = UNTAG_TYPE;
    if (pke.in_pke_data[31:16] == PTP_ETYPE)       pkttype_d = PTP_TYPE;
    else if (pke.in_pke_data[31:16] == VLAN_ETYPE) pkttype_d = PCP_MAP[map_lsb +: 3];
  end

  // NOTE: state register uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_en   = 1'b0;
    load_in    = 1'b0;
    emit       = 1'b0;
    emit_last  = 1'b0;
    head_start = 1'b0;
    classify   = 1'b0;
    err_inc    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept && is_head) begin
          head_start = 1'b1;
          shift_en   = 1'b1;
          load_in    = 1'b1;
          cnt_d      = 3'd1;
          state_d    = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (accept) begin
          if (is_head) begin
            err_inc    = 1'b1;
            head_start = 1'b1;
            shift_en   = 1'b1;
            load_in    = 1'b1;
            cnt_d      = 3'd1;
          end else if (is_tail && (cnt_inc < DEPTH_C)) begin
            err_inc = 1'b1;
            cnt_d   = '0;
            state_d = S_IDLE;
          end else begin
            shift_en = 1'b1;
            load_in  = 1'b1;
            cnt_d    = cnt_inc;
            if (cnt_inc == DEPTH_C) begin
              classify = 1'b1;
              state_d  = is_tail ? S_DRAIN : S_PASS;
            end
          end
        end
      end
      S_PASS: begin
        if (accept) begin
          shift_en = 1'b1;
          load_in  = 1'b1;
          if (is_head) begin
            // Missing tail: frames already forwarded stand, the new head restarts collection.
            err_inc    = 1'b1;
            head_start = 1'b1;
            cnt_d      = 3'd1;
            state_d    = S_COLLECT;
          end else begin
            emit = 1'b1;
            if (is_tail) begin
              cnt_d   = DEPTH_C;
              state_d = S_DRAIN;
            end
          end
        end
      end
      S_DRAIN: begin
        shift_en = 1'b1;
        emit     = 1'b1;
        cnt_d    = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          emit_last = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: the frame buffer is plain flops, so it is cleared by the async reset like any other state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q       <= '0;
      out_data_q  <= '0;
      out_wr_q    <= 1'b0;
      out_valid_q <= 1'b0;
      pkttype_q   <= '0;
      key_q       <= '0;
    end else begin
      // Newest frame enters at the top; after DEPTH stores buf_q[0] is the packet's first frame.
      if (shift_en) buf_q <= {(load_in ? pke.in_pke_data : 134'd0), buf_q[DEPTH-1:1]};
      out_data_q  <= emit ? buf_q[0] : '0;
      out_wr_q    <= emit;
      out_valid_q <= emit_last;
      if (head_start) key_q[5:0] <= pke.in_pke_data[125:120];
      if (classify) begin
        key_q[101:6] <= pke.in_pke_data[127:32];
        pkttype_q    <= pkttype_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      esw_pktin_cnt <= '0;
      pke_err_cnt   <= '0;
    end else begin
      if (pke.in_pke_valid_wr && (esw_pktin_cnt != '1)) esw_pktin_cnt <= esw_pktin_cnt + 64'd1;
      if (err_inc && (pke_err_cnt != '1))               pke_err_cnt   <= pke_err_cnt + 32'd1;
    end
  end

  assign pke.in_pke_ready     = ready;
  assign pke.out_pke_data     = out_data_q;
  assign pke.out_pke_data_wr  = out_wr_q;
  assign pke.out_pke_valid    = out_valid_q;
  assign pke.out_pke_valid_wr = out_valid_q;
  assign pke.out_pke_pkttype  = pkttype_q;
  assign pke.out_pke_key      = key_q;

endmodule

// File: tb/tb_pke_v2.sv
// Randomized bench for pke_v2: a packet-level model predicts every output frame,
// the cycle it must appear on, its key/pkttype, the ready pattern and both counters.
module tb_pke_v2;
  localparam int MD = 2;
  localparam int D  = MD + 1;

  typedef struct {
    logic [133:0] data;
    logic         last;
    logic [2:0]   pt;
    logic [101:0] key;
    int           at;
  } exp_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] esw_pktin_cnt;
  logic [31:0] pke_err_cnt;

  pke_v2_if pke();

  pke_v2 #(.MD_FRAMES(MD)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pke          (pke),
    .esw_pktin_cnt(esw_pktin_cnt),
    .pke_err_cnt  (pke_err_cnt)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  exp_t        exp_q[$];
  int          exp_err = 0;
  logic [63:0] exp_pktin = '0;
  bit          pending_abort = 1'b0;
  int          drain_lo = 0;
  int          drain_hi = -1;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [133:0] got, input logic [133:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  // Traffic class table for PCP 0..7 under the default map.
  function automatic logic [2:0] ref_type(input logic [15:0] et, input logic [2:0] pcp);
    logic [2:0] tbl [8];
    tbl = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd1, 3'd3, 3'd3};
    if (et == 16'h88F7) return 3'd2;
    if (et == 16'h8100) return tbl[pcp];
    return 3'd0;
  endfunction

  function automatic logic [133:0] mk(input logic [1:0] code);
    logic [133:0] f;
    f[31:0]    = $urandom;
    f[63:32]   = $urandom;
    f[95:64]   = $urandom;
    f[127:96]  = $urandom;
    f[133:128] = 6'($urandom);
    f[133:132] = code;
    return f;
  endfunction

  function automatic logic [15:0] rand_etype();
    case ($urandom_range(0, 3))
      0:       return 16'h8100;
      1:       return 16'h88F7;
      2:       return 16'h0800;
      default: return 16'($urandom);
    endcase
  endfunction

  // Every output cycle is compared: either the expected frame due now, or an all-zero idle bus.
  always @(negedge clk) begin
    exp_t x;
    if (exp_q.size() > 0 && exp_q[0].at == cyc) begin
      x = exp_q.pop_front();
      check("out_wr",       134'(pke.out_pke_data_wr),  134'(1'b1));
      check("out_data",     pke.out_pke_data,           x.data);
      check("out_valid",    134'(pke.out_pke_valid),    134'(x.last));
      check("out_valid_wr", 134'(pke.out_pke_valid_wr), 134'(x.last));
      check("pkttype",      134'(pke.out_pke_pkttype),  134'(x.pt));
      check("key",          134'(pke.out_pke_key),      134'(x.key));
    end else begin
      check("idle_wr",    134'(pke.out_pke_data_wr), 134'(1'b0));
      check("idle_data",  pke.out_pke_data,          134'd0);
      check("idle_valid", 134'({pke.out_pke_valid, pke.out_pke_valid_wr}), 134'(2'b00));
    end
  end

  task automatic quiet();
    pke.in_pke_data     = '0;
    pke.in_pke_data_wr  = 1'b0;
    pke.in_pke_valid    = 1'b0;
    pke.in_pke_valid_wr = 1'b0;
  endtask

  // One input cycle; e is the clock edge that samples it.
  task automatic drive(input bit wr, input logic [133:0] d, output int e);
    bit vw;
    e  = cyc + 1;
    vw = ($urandom_range(0, 3) == 0);
    pke.in_pke_data     = d;
    pke.in_pke_data_wr  = wr;
    pke.in_pke_valid    = vw;
    pke.in_pke_valid_wr = vw;
    if (vw) exp_pktin++;
    check("ready", 134'(pke.in_pke_ready), 134'(!(e >= drain_lo && e <= drain_hi)));
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    int e;
    repeat (n) drive(1'b0, mk(2'b01), e);
  endtask

  task automatic push(input logic [133:0] d, input bit last, input logic [2:0] pt,
                      input logic [101:0] key, input int at);
    exp_t x;
    x.data = d;
    x.last = last;
    x.pt   = pt;
    x.key  = key;
    x.at   = at;
    exp_q.push_back(x);
  endtask

  task automatic send_packet(input int len, input bit tail, input logic [15:0] etype,
                             input logic [2:0] pcp, input logic [5:0] inport,
                             input int max_gap, input bit junk);
    logic [133:0] fr [$];
    logic [133:0] f;
    logic [101:0] key;
    logic [2:0]   pt;
    int           e;
    for (int i = 0; i < len; i++) begin
      f = mk((i == 0) ? 2'b01 : (tail && i == len - 1) ? 2'b10 : 2'b11);
      if (i == 0) f[125:120] = inport;
      if (i == D - 1) begin
        f[31:16] = etype;
        f[15:13] = pcp;
      end
      fr.push_back(f);
    end
    key = '0;
    if (len >= D) key = {fr[D-1][127:32], inport};
    pt = ref_type(etype, pcp);
    if (pending_abort) begin
      exp_err++;
      pending_abort = 1'b0;
    end
    e = cyc;
    for (int i = 0; i < len; i++) begin
      if (i > 0 && max_gap > 0) idle($urandom_range(0, max_gap));
      e = cyc + 1;
      // Once the buffer is full each accepted frame releases the frame D positions older.
      if (i >= D) push(fr[i-D], 1'b0, pt, key, e);
      drive(1'b1, fr[i], e);
    end
    if (!tail) pending_abort = 1'b1;
    else if (len < D) exp_err++;
    else begin
      drain_lo = e + 1;
      drain_hi = e + D;
      for (int k = 1; k <= D; k++) push(fr[len-D+k-1], k == D, pt, key, e + k);
      for (int k = 0; k < D; k++) drive(junk, mk(2'b01), e);
    end
    idle(1);
    check("err_cnt",   134'(pke_err_cnt),   134'(exp_err));
    check("pktin_cnt", 134'(esw_pktin_cnt), 134'(exp_pktin));
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_ready"},   134'(pke.in_pke_ready),    134'(1'b1));
    check({tag, "_out_wr"},  134'(pke.out_pke_data_wr), 134'(1'b0));
    check({tag, "_pkttype"}, 134'(pke.out_pke_pkttype), 134'd0);
    check({tag, "_key"},     134'(pke.out_pke_key),     134'd0);
    check({tag, "_err"},     134'(pke_err_cnt),         134'd0);
    check({tag, "_pktin"},   134'(esw_pktin_cnt),       134'd0);
  endtask

  initial begin
    int kind;
    int e;
    quiet();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_checks("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Back-to-back 5-frame VLAN PCP 6 packet, then PTP classification.
    send_packet(5, 1'b1, 16'h8100, 3'd6, 6'h2A, 0, 1'b0);
    send_packet(D, 1'b1, 16'h88F7, 3'd0, 6'h15, 0, 1'b1);
    // Short packet is dropped, the following one goes through.
    send_packet(2, 1'b1, 16'h8100, 3'd7, 6'h01, 0, 1'b0);
    send_packet(6, 1'b1, 16'h8100, 3'd3, 6'h02, 0, 1'b0);
    // Long packet with input gaps while passing.
    send_packet(9, 1'b1, 16'h0800, 3'd0, 6'h03, 3, 1'b0);
    // Head arriving in PASS after 4 frames aborts the packet.
    send_packet(4, 1'b0, 16'h8100, 3'd5, 6'h04, 1, 1'b0);
    send_packet(5, 1'b1, 16'h88F7, 3'd0, 6'h05, 1, 1'b0);
    for (int p = 0; p < 8; p++) send_packet(D + 1, 1'b1, 16'h8100, 3'(p), 6'(p), 0, 1'b0);
    send_packet(D, 1'b1, 16'h0800, 3'd6, 6'h3F, 0, 1'b0);

    // Non-head frames in IDLE are discarded silently.
    drive(1'b1, mk(2'b11), e);
    drive(1'b1, mk(2'b10), e);
    idle(1);
    check("stray_err", 134'(pke_err_cnt), 134'(exp_err));

    // Reset in the middle of collection: nothing emitted, counters cleared.
    send_packet(2, 1'b0, 16'h8100, 3'd1, 6'h06, 0, 1'b0);
    quiet();
    rst_n = 1'b0;
    @(negedge clk);
    reset_checks("midrst");
    rst_n = 1'b1;
    pending_abort = 1'b0;
    exp_err       = 0;
    exp_pktin     = '0;
    @(negedge clk);
    send_packet(D + 2, 1'b1, 16'h8100, 3'd4, 6'h07, 1, 1'b0);

    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 9);
      if (kind == 6) begin
        send_packet($urandom_range(2, D - 1), 1'b1, rand_etype(), 3'($urandom), 6'($urandom), 1, 1'b0);
      end else if (kind == 7) begin
        send_packet($urandom_range(1, D + 3), 1'b0, rand_etype(), 3'($urandom), 6'($urandom), 2, 1'b0);
      end else if (kind == 8 && !pending_abort) begin
        drive(1'b1, mk(2'b11), e);
        drive(1'b1, mk(2'b10), e);
        idle(1);
      end else begin
        send_packet($urandom_range(D, D + 4), 1'b1, rand_etype(), 3'($urandom), 6'($urandom),
                    $urandom_range(0, 2), 1'($urandom));
      end
    end
    if (pending_abort) send_packet(D + 1, 1'b1, 16'h8100, 3'd6, 6'h08, 0, 1'b0);

    idle(D + 2);
    quiet();
    check("final_err",   134'(pke_err_cnt),   134'(exp_err));
    check("final_pktin", 134'(esw_pktin_cnt), 134'(exp_pktin));
    check("exp_q_empty", 134'(exp_q.size()),  134'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/pke_v2.md
PKE_V2 -- requirements
Module: pke_v2

Interface
REQ-001 Parameter MD_FRAMES, default 2: number of metadata frames preceding the Ethernet header frame (legal 1..4).
REQ-002 Parameter PCP_MAP, default 24'o33111000: 3 bits per PCP value, so PCP p maps to pkttype PCP_MAP[3p+2:3p].
REQ-003 Parameter PTP_ETYPE, default 16'h88F7: ethertype classified as PTP.
REQ-004 Parameter VLAN_ETYPE, default 16'h8100: ethertype classified as VLAN-tagged.
REQ-005 Parameter UNTAG_TYPE, default 3'h0: pkttype for non-PTP untagged frames.
REQ-006 Parameters PTP_TYPE, default 3'h2: pkttype for PTP frames.
REQ-007 clk  in  1  clock; all logic on rising edge.
REQ-008 rst_n  in  1  reset, asynchronous, active-low.
REQ-009 in_pke_data  in  134  frame; [133:132] 01=head, 11=middle, 10=tail.
REQ-010 in_pke_data_wr  in  1  frame strobe, accepted only when in_pke_ready=1.
REQ-011 in_pke_valid / in_pke_valid_wr  in  1 each  per-packet valid and strobe (counted only).
REQ-012 in_pke_ready  out  1  block can accept a frame this cycle.
REQ-013 out_pke_data  out  134  frame out.
REQ-014 out_pke_data_wr  out  1  out frame strobe.
REQ-015 out_pke_valid / out_pke_valid_wr  out  1 each  asserted together with the tail frame.
REQ-016 out_pke_pkttype  out  3  0=best effort, 1=reserved BW, 2=PTP, 3=TSN (via map).
REQ-017 out_pke_key  out  102  [5:0]=inport, [101:6]=DMAC+SMAC.
REQ-018 esw_pktin_cnt  out  64  count of in_pke_valid_wr pulses.
REQ-019 pke_err_cnt  out  32  count of dropped malformed packets.

Function
REQ-020 Buffer depth D = MD_FRAMES+1 frames (metadata plus header frame), held in a shift buffer.
REQ-021 States: IDLE, COLLECT, PASS, DRAIN.
REQ-022 IDLE: accepted frame with head code 01 -> store it, latch key[5:0]=data[125:120], frame count=1, go COLLECT; non-head frames are discarded silently.
REQ-023 COLLECT: each accepted frame is stored; when frame D is stored, latch key[101:6]=data[127:32] and classify from data[31:16] and data[15:13]; then go PASS, or DRAIN if frame D is a tail.
REQ-024 Classification: ethertype==PTP_ETYPE -> PTP_TYPE; ethertype==VLAN_ETYPE -> PCP_MAP entry for PCP; otherwise UNTAG_TYPE.
REQ-025 Key and pkttype are stable from the first output frame of a packet through its tail.
REQ-026 PASS: each accepted frame pushes the oldest buffered frame to the output on the next cycle (registered, latency 1); no output when no frame is accepted.
REQ-027 PASS: on an accepted tail -> go DRAIN.
REQ-028 DRAIN: in_pke_ready=0; the D remaining frames are emitted on consecutive cycles; the last emitted (tail) frame carries out_pke_valid=1 and out_pke_valid_wr=1 for one cycle; then go IDLE.
REQ-029 in_pke_ready=1 in IDLE, COLLECT and PASS.
REQ-030 Tail accepted in COLLECT before frame D (short packet) -> discard buffer, pke_err_cnt+1, go IDLE, no output.
REQ-031 Head accepted in COLLECT or PASS (missing tail) -> abort current packet, pke_err_cnt+1; in PASS, the frames already emitted stand and no valid is produced. The new head starts a fresh COLLECT.
REQ-032 Counters saturate at all-ones; esw_pktin_cnt increments independently of state.
REQ-033 Outputs are zero whenever out_pke_data_wr=0 (data) and whenever no tail is emitted (valid, valid_wr).

Reset
REQ-034 rst_n low forces IDLE, empties the buffer, and zeroes all outputs and counters; in_pke_ready=1 after release.
REQ-035 Reset mid-packet discards the partial packet with no output and no error count.

Verification
REQ-036 MD_FRAMES=2, 5-frame packet, header ethertype 8100 PCP=6, back-to-back -> 5 frames out identical and in order, pkttype=3, valid_wr on frame 5, ready low 3 cycles.
REQ-037 Ethertype 88F7, inport=6'h15 -> pkttype=2, key[5:0]=15, key[101:6]=header[127:32].
REQ-038 2-frame packet (tail at frame 2) -> no output, pke_err_cnt=1, next packet is processed normally.
REQ-039 Middle frames with gaps in data_wr during PASS -> output strobes mirror the input gaps with 1-cycle latency; no duplication or loss.
REQ-040 Head arriving in PASS after 4 frames -> err=1, no valid; the new packet completes correctly.
REQ-041 PCP sweep 0..7 with default map -> pkttypes 0,0,0,1,1,1,3,3; untagged 0800 -> 0.
